// File: rtl/sift_cov_pkg.sv
// Shared constants and state encoding for the convolution window feeder.
package sift_cov_pkg;

  localparam int DW        = 10;
  localparam int NTAP      = 8;
  localparam int FLUSH_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/win_shift8.sv
// Eight-deep pixel window: parallel load of one value or a shift toward w1.
module win_shift8 #(
  parameter int DW = sift_cov_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_all,
  input  logic          shift,
  input  logic [DW-1:0] shift_data,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w3,
  output logic [DW-1:0] w4,
  output logic [DW-1:0] w5,
  output logic [DW-1:0] w6,
  output logic [DW-1:0] w7,
  output logic [DW-1:0] w8
);
  import sift_cov_pkg::*;

  logic [DW-1:0] w [NTAP];

  // Load replicates the line's first pixel into every tap; shift moves toward w1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAP; i++) w[i] <= '0;
    end else if (load_all) begin
      for (int i = 0; i < NTAP; i++) w[i] <= shift_data;
    end else if (shift) begin
      for (int i = 0; i < NTAP - 1; i++) w[i] <= w[i+1];
      w[NTAP-1] <= shift_data;
    end
  end

  assign w1 = w[0];
  assign w2 = w[1];
  assign w3 = w[2];
  assign w4 = w[3];
  assign w5 = w[4];
  assign w6 = w[5];
  assign w7 = w[6];
  assign w8 = w[7];

endmodule

// File: rtl/cov_window_feeder.sv
// Turns a raster pixel stream into edge-replicated 8-tap windows, one per column.
module cov_window_feeder #(
  parameter int DW     = sift_cov_pkg::DW,
  parameter int LINE_W = 640,
  parameter int COL_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    pix_in,
  input  logic             pix_valid,
  input  logic             pix_sol,
  output logic             pix_ready,
  output logic [DW-1:0]    din1,
  output logic [DW-1:0]    din2,
  output logic [DW-1:0]    din3,
  output logic [DW-1:0]    din4,
  output logic [DW-1:0]    din5,
  output logic [DW-1:0]    din6,
  output logic [DW-1:0]    din7,
  output logic [DW-1:0]    din8,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic             win_eol,
  output logic             line_err
);
  import sift_cov_pkg::*;

  // Column 0 is complete once pixels 0..4 are in: the window spans c-3..c+4.
  localparam logic [COL_W:0] COL0_CNT = (COL_W+1)'(NTAP - FLUSH_LEN + 1);
  localparam logic [COL_W:0] LAST_CNT = (COL_W+1)'(LINE_W);
  localparam logic [1:0]     LAST_FL  = 2'(FLUSH_LEN - 1);

  state_t          state;
  logic [COL_W:0]  in_cnt;
  logic [COL_W:0]  in_nxt;
  logic [1:0]      flush_cnt;
  logic            accept;
  logic            load_all;
  logic            shift;
  logic [DW-1:0]   shift_data;

  assign accept     = pix_valid & pix_ready;
  assign in_nxt     = in_cnt + 1'b1;
  assign load_all   = accept & pix_sol;
  assign shift      = (state == FLUSH) |
                      (accept & ~pix_sol & ((state == FILL) | (state == RUN)));
  // During flush the last pixel is re-fed to replicate the right edge.
  assign shift_data = (state == FLUSH) ? din8 : pix_in;

  win_shift8 #(.DW(DW)) u_win (
    .clk        (clk),
    .rst        (rst),
    .load_all   (load_all),
    .shift      (shift),
    .shift_data (shift_data),
    .w1         (din1),
    .w2         (din2),
    .w3         (din3),
    .w4         (din4),
    .w5         (din5),
    .w6         (din6),
    .w7         (din7),
    .w8         (din8)
  );

  // Line framing FSM with registered handshake, window-valid and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pix_ready <= 1'b0;
      in_cnt    <= '0;
      flush_cnt <= '0;
      win_col   <= '0;
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      line_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (accept) begin
            if (pix_sol) begin
              in_cnt  <= (COL_W+1)'(1);
              win_col <= '0;
              state   <= FILL;
            end else begin
              line_err <= 1'b1;
            end
          end
        end
        FILL, RUN: begin
          if (accept) begin
            if (pix_sol) begin
              // A new start-of-line aborts the current line without flushing.
              line_err <= 1'b1;
              in_cnt   <= (COL_W+1)'(1);
              win_col  <= '0;
              state    <= FILL;
            end else begin
              in_cnt <= in_nxt;
              if (state == RUN) begin
                win_valid <= 1'b1;
                win_col   <= win_col + 1'b1;
              end else if (in_nxt == COL0_CNT) begin
                win_valid <= 1'b1;
                win_col   <= '0;
                state     <= RUN;
              end
              if ((state == RUN || in_nxt == COL0_CNT) && in_nxt == LAST_CNT) begin
                state     <= FLUSH;
                pix_ready <= 1'b0;
                flush_cnt <= '0;
              end
            end
          end
        end
        FLUSH: begin
          win_valid <= 1'b1;
          win_col   <= win_col + 1'b1;
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == LAST_FL) begin
            win_eol   <= 1'b1;
            pix_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cov_window_feeder.sv
// Scoreboard bench: two feeders (LINE_W=8 and LINE_W=5) driven by directed lines.
module tb_cov_window_feeder;
  localparam int DW    = 10;
  localparam int COL_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [DW-1:0]    pix_in    [2];
  logic             pix_valid [2];
  logic             pix_sol   [2];
  logic             pix_ready [2];
  logic [DW-1:0]    din       [2][8];
  logic             win_valid [2];
  logic [COL_W-1:0] win_col   [2];
  logic             win_eol   [2];
  logic             line_err  [2];

  cov_window_feeder #(.DW(DW), .LINE_W(8), .COL_W(COL_W)) dut8 (
    .clk(clk), .rst(rst), .pix_in(pix_in[0]), .pix_valid(pix_valid[0]),
    .pix_sol(pix_sol[0]), .pix_ready(pix_ready[0]),
    .din1(din[0][0]), .din2(din[0][1]), .din3(din[0][2]), .din4(din[0][3]),
    .din5(din[0][4]), .din6(din[0][5]), .din7(din[0][6]), .din8(din[0][7]),
    .win_valid(win_valid[0]), .win_col(win_col[0]), .win_eol(win_eol[0]),
    .line_err(line_err[0])
  );

  cov_window_feeder #(.DW(DW), .LINE_W(5), .COL_W(COL_W)) dut5 (
    .clk(clk), .rst(rst), .pix_in(pix_in[1]), .pix_valid(pix_valid[1]),
    .pix_sol(pix_sol[1]), .pix_ready(pix_ready[1]),
    .din1(din[1][0]), .din2(din[1][1]), .din3(din[1][2]), .din4(din[1][3]),
    .din5(din[1][4]), .din6(din[1][5]), .din7(din[1][6]), .din8(din[1][7]),
    .win_valid(win_valid[1]), .win_col(win_col[1]), .win_eol(win_eol[1]),
    .line_err(line_err[1])
  );

  typedef struct packed {
    logic                  d;
    logic [7:0][DW-1:0]    w;
    logic [COL_W-1:0]      col;
    logic                  eol;
  } win_t;

  win_t exp_q[$];
  win_t act_w;
  win_t exp_w;
  int   total = 0;
  int   bad   = 0;
  int   err_seen [2] = '{0, 0};
  int   lb [8];

  // Monitor: every presented window is popped against the expected queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (line_err[d] === 1'b1) err_seen[d]++;
      if (win_valid[d] === 1'b1) begin
        act_w.d = d[0];
        for (int k = 0; k < 8; k++) act_w.w[k] = din[d][k];
        act_w.col = win_col[d];
        act_w.eol = win_eol[d];
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window dut%0d got col=%0d eol=%0d w=%h required none",
                   d, act_w.col, act_w.eol, act_w.w);
        end else begin
          exp_w = exp_q.pop_front();
          if (act_w !== exp_w) begin
            bad++;
            $display("FAIL window dut%0d got d=%0d col=%0d eol=%0d w=%h required d=%0d col=%0d eol=%0d w=%h",
                     d, act_w.d, act_w.col, act_w.eol, act_w.w,
                     exp_w.d, exp_w.col, exp_w.eol, exp_w.w);
          end
        end
      end else if (win_eol[d] === 1'b1) begin
        total++;
        bad++;
        $display("FAIL stray_eol dut%0d got win_eol=1 with win_valid=0 required 0", d);
      end
    end
  end

  task automatic check(input string nm, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got %0d required %0d", nm, a, e);
    end
  endtask

  task automatic push_w(input int d, input int c, input bit eol,
                        input int a0, input int a1, input int a2, input int a3,
                        input int a4, input int a5, input int a6, input int a7);
    win_t x;
    x.d = d[0];
    x.w[0] = DW'(a0); x.w[1] = DW'(a1); x.w[2] = DW'(a2); x.w[3] = DW'(a3);
    x.w[4] = DW'(a4); x.w[5] = DW'(a5); x.w[6] = DW'(a6); x.w[7] = DW'(a7);
    x.col = COL_W'(c);
    x.eol = eol;
    exp_q.push_back(x);
  endtask

  // Window of column c from line buffer lb, clamped at both line ends.
  task automatic push_model(input int d, input int len, input int c);
    win_t x;
    int idx;
    x.d = d[0];
    for (int k = 0; k < 8; k++) begin
      idx = c - 3 + k;
      if (idx < 0) idx = 0;
      if (idx > len - 1) idx = len - 1;
      x.w[k] = DW'(lb[idx]);
    end
    x.col = COL_W'(c);
    x.eol = (c == len - 1);
    exp_q.push_back(x);
  endtask

  task automatic send(input int d, input int v, input bit sol);
    int n = 0;
    while (pix_ready[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL ready_timeout dut%0d got pix_ready=0 required 1", d);
    end
    pix_in[d] = DW'(v); pix_sol[d] = sol; pix_valid[d] = 1'b1;
    @(posedge clk); #1;
    pix_valid[d] = 1'b0; pix_sol[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || pix_ready[0] !== 1'b1 || pix_ready[1] !== 1'b1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    idle(2);
    check(nm, exp_q.size(), 0);
  endtask

  task automatic count_ready_low(input int d, output int n0);
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pix_ready[d] === 1'b1) break;
      n0++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int d = 0; d < 2; d++) begin
      pix_in[d] = '0; pix_valid[d] = 1'b0; pix_sol[d] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_ready",     int'(pix_ready[0]), 0);
    check("rst_valid",     int'(win_valid[0]), 0);
    check("rst_col",       int'(win_col[0]),   0);
    check("rst_din1",      int'(din[0][0]),    0);
    check("rst_err",       int'(line_err[0]),  0);
    #10;
    check("rst_hold_ready", int'(pix_ready[0]), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst8", int'(pix_ready[0]), 1);
    check("ready_after_rst5", int'(pix_ready[1]), 1);

    // Continuous line 10..17
    push_w(0, 0, 0, 10,10,10,10,11,12,13,14);
    push_w(0, 1, 0, 10,10,10,11,12,13,14,15);
    push_w(0, 2, 0, 10,10,11,12,13,14,15,16);
    push_w(0, 3, 0, 10,11,12,13,14,15,16,17);
    push_w(0, 4, 0, 11,12,13,14,15,16,17,17);
    push_w(0, 5, 0, 12,13,14,15,16,17,17,17);
    push_w(0, 6, 0, 13,14,15,16,17,17,17,17);
    push_w(0, 7, 1, 14,15,16,17,17,17,17,17);
    for (int i = 0; i < 8; i++) send(0, 10 + i, i == 0);
    count_ready_low(0, n0);
    check("flush_ready_low8", n0, 4);
    drain("drain_line1");
    check("no_err_line1", err_seen[0], 0);

    // Same line with pix_valid toggling
    for (int i = 0; i < 8; i++) lb[i] = 10 + i;
    for (int c = 0; c < 8; c++) push_model(0, 8, c);
    for (int i = 0; i < 8; i++) begin
      send(0, 10 + i, i == 0);
      idle(1);
    end
    drain("drain_stall");

    // Pixel without start-of-line in IDLE
    send(0, 5, 1'b0);
    idle(3);
    check("err_no_sol", err_seen[0], 1);
    check("no_window_no_sol", exp_q.size(), 0);
    for (int c = 0; c < 8; c++) push_model(0, 8, c);
    for (int i = 0; i < 8; i++) send(0, 10 + i, i == 0);
    drain("drain_after_err");

    // Start-of-line on the 6th pixel aborts the line
    for (int i = 0; i < 5; i++) lb[i] = 40 + i;
    push_model(0, 8, 0);
    for (int i = 0; i < 5; i++) send(0, 40 + i, i == 0);
    for (int i = 0; i < 8; i++) lb[i] = 50 + i;
    for (int c = 0; c < 8; c++) push_model(0, 8, c);
    for (int i = 0; i < 8; i++) send(0, 50 + i, i == 0);
    drain("drain_abort");
    check("err_abort", err_seen[0], 2);

    // Asynchronous reset mid-line right after col 2 is produced
    for (int i = 0; i < 8; i++) lb[i] = 20 + i;
    push_model(0, 8, 0);
    push_model(0, 8, 1);
    for (int i = 0; i < 7; i++) send(0, 20 + i, i == 0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(win_valid[0]), 0);
    check("mid_rst_ready", int'(pix_ready[0]), 0);
    check("mid_rst_col",   int'(win_col[0]),   0);
    check("mid_rst_din1",  int'(din[0][0]),    0);
    check("mid_rst_din8",  int'(din[0][7]),    0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready_after", int'(pix_ready[0]), 1);
    check("mid_rst_queue", exp_q.size(), 0);
    for (int i = 0; i < 8; i++) lb[i] = 30 + i;
    for (int c = 0; c < 8; c++) push_model(0, 8, c);
    for (int i = 0; i < 8; i++) send(0, 30 + i, i == 0);
    drain("drain_after_rst");

    // Minimum line width
    push_w(1, 0, 0, 1,1,1,1,2,3,4,5);
    push_w(1, 1, 0, 1,1,1,2,3,4,5,5);
    push_w(1, 2, 0, 1,1,2,3,4,5,5,5);
    push_w(1, 3, 0, 1,2,3,4,5,5,5,5);
    push_w(1, 4, 1, 2,3,4,5,5,5,5,5);
    for (int i = 0; i < 5; i++) send(1, 1 + i, i == 0);
    count_ready_low(1, n0);
    check("flush_ready_low5", n0, 4);
    drain("drain_w5");
    check("no_err_w5", err_seen[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
